i2c_target_regs: RTL

Parametrised I2C target (slave) with a built-in register file, succeeding the fixed-address start/ACK detector. Sits between the board-level open-drain SCL/SDA pins and on-chip logic. Supports write, read, repeated START and auto-incrementing register pointer. Exposes register contents and write strobes to the fabric.

---
 rtl/i2c_pkg.sv | 20 ++
 rtl/i2c_target_regs_if.sv | 9 +
 rtl/i2c_line_cond.sv | 69 ++++++
 rtl/i2c_target_regs.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target register block.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    IGNORE
  } i2c_state_t;

  localparam int GLITCH_LEN = 5;
  localparam int BIT_CNT_W  = 4;

endpackage

// File: rtl/i2c_target_regs_if.sv
// Conditioned I2C line: settled level plus one-cycle rise/fall strobes.
interface i2c_line_if;
  logic level;
  logic rise;
  logic fall;

  modport master (output level, output rise, output fall);
  modport slave  (input  level, input  rise, input  fall);
endinterface

// File: rtl/i2c_line_cond.sv
// Synchroniser, optional glitch filter (I2C_GLITCH_FILTER_EN) and edge detector
// for one open-drain I2C line. Lines idle high, so every stage resets to 1.
module i2c_line_cond
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      pin,
  i2c_line_if.master line
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   filt;
  logic                   prev_q;
  logic                   rise_q;
  logic                   fall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '1;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
  end

`ifdef I2C_GLITCH_FILTER_EN
  localparam int GW = $clog2(GLITCH_LEN);
  logic          cand_q;
  logic          filt_q;
  logic [GW-1:0] stable_q;

  // A new level is accepted only once it has held for GLITCH_LEN cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_q   <= 1'b1;
      filt_q   <= 1'b1;
      stable_q <= '0;
    end else if (sync_q[SYNC_STAGES-1] != cand_q) begin
      cand_q   <= sync_q[SYNC_STAGES-1];
      stable_q <= '0;
    end else if (stable_q == GW'(GLITCH_LEN - 1)) begin
      filt_q   <= cand_q;
    end else begin
      stable_q <= stable_q + 1'b1;
    end
  end

  assign filt = filt_q;
`else
  assign filt = sync_q[SYNC_STAGES-1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b1;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      prev_q <= filt;
      rise_q <= filt & ~prev_q;
      fall_q <= ~filt & prev_q;
    end
  end

  // prev_q already holds the post-edge level in the cycle the strobe is high.
  assign line.level = prev_q;
  assign line.rise  = rise_q;
  assign line.fall  = fall_q;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target with auto-incrementing register file. Optional glitch filtering on
// SCL/SDA is enabled with the I2C_GLITCH_FILTER_EN macro (see i2c_line_cond).
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = 7'h42,
  parameter int         NUM_REGS    = 16,
  parameter int         SYNC_STAGES = 2,
  parameter int         HOLD_CYCLES = 30,
  localparam int        IDX_W       = $clog2(NUM_REGS)
) (
  input  logic                  clk100,
  input  logic                  reset_n,
  inout  wire                   ck_scl,
  inout  wire                   ck_sda,
  output logic                  start_detected_w,
  output logic                  stop_detected_w,
  output logic                  ack_in_progress_w,
  output logic                  busy_w,
  output logic                  reg_wr_stb,
  output logic [IDX_W-1:0]      reg_wr_idx,
  output logic [8*NUM_REGS-1:0] regs_flat,
  output i2c_state_t            dbg_state
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

  i2c_line_if scl_l ();
  i2c_line_if sda_l ();

  i2c_line_cond #(.SYNC_STAGES(SYNC_STAGES)) u_scl_cond (
    .clk(clk100), .rst_n(reset_n), .pin(ck_scl), .line(scl_l)
  );
  i2c_line_cond #(.SYNC_STAGES(SYNC_STAGES)) u_sda_cond (
    .clk(clk100), .rst_n(reset_n), .pin(ck_sda), .line(sda_l)
  );

  // An SCL edge in the same cycle means a data transition, not START/STOP.
  logic start, stop;
  assign start = sda_l.fall & scl_l.level & ~scl_l.rise & ~scl_l.fall;
  assign stop  = sda_l.rise & scl_l.level & ~scl_l.rise & ~scl_l.fall;

  i2c_state_t           state_q, state_d;
  logic [BIT_CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]           rx_q, rx_d;
  logic [6:0]           tx_q, tx_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic                 ack_bit_q, ack_bit_d;
  logic                 drv_req, drv_oe, drv_ack, wr_en;
  logic [7:0]           wr_data, cur_byte;
  logic [7:0]           regs [NUM_REGS];

  logic                 oe_q, oe_ack_q, pend_oe_q, pend_ack_q, hold_act_q;
  logic [HOLD_W-1:0]    hold_q;
  logic                 wr_stb_q;
  logic [IDX_W-1:0]     wr_idx_q;

  assign cur_byte = regs[ptr_q];

  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // All SDA changes are requested on a detected SCL fall and applied after the hold delay.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    ptr_d     = ptr_q;
    ack_bit_d = ack_bit_q;
    drv_req   = 1'b0;
    drv_oe    = 1'b0;
    drv_ack   = 1'b0;
    wr_en     = 1'b0;
    wr_data   = {rx_q[6:0], sda_l.level};
    if (stop) begin
      state_d = IDLE;
    end else if (start) begin
      state_d = ADDR;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ADDR, PTR, WR_DATA: begin
          if (scl_l.rise) begin
            rx_d  = wr_data;
            cnt_d = cnt_q + 1'b1;
            if (state_q == WR_DATA && cnt_q == BIT_CNT_W'(7)) begin
              wr_en = 1'b1;
              ptr_d = ptr_q + 1'b1;
            end
          end else if (scl_l.fall && cnt_q == BIT_CNT_W'(8)) begin
            cnt_d   = '0;
            drv_req = 1'b1;
            drv_oe  = 1'b1;
            drv_ack = 1'b1;
            case (state_q)
              ADDR: begin
                if (rx_q[7:1] == TARGET_ADDR) begin
                  state_d = ADDR_ACK;
                end else begin
                  state_d = IGNORE;
                  drv_oe  = 1'b0;
                  drv_ack = 1'b0;
                end
              end
              PTR: begin
                ptr_d   = rx_q[IDX_W-1:0];
                state_d = PTR_ACK;
              end
              default: state_d = WR_ACK;
            endcase
          end
        end
        ADDR_ACK: begin
          if (scl_l.fall) begin
            cnt_d   = '0;
            drv_req = 1'b1;
            if (rx_q[0]) begin
              state_d = RD_DATA;
              tx_d    = cur_byte[6:0];
              drv_oe  = ~cur_byte[7];
            end else begin
              state_d = PTR;
            end
          end
        end
        PTR_ACK, WR_ACK: begin
          if (scl_l.fall) begin
            state_d = WR_DATA;
            cnt_d   = '0;
            drv_req = 1'b1;
          end
        end
        RD_DATA: begin
          if (scl_l.fall) begin
            drv_req = 1'b1;
            if (cnt_q == BIT_CNT_W'(7)) begin
              cnt_d   = '0;
              ptr_d   = ptr_q + 1'b1;
              state_d = RD_ACK;
            end else begin
              cnt_d  = cnt_q + 1'b1;
              tx_d   = {tx_q[5:0], 1'b0};
              drv_oe = ~tx_q[6];
            end
          end
        end
        RD_ACK: begin
          if (scl_l.rise) begin
            ack_bit_d = sda_l.level;
          end else if (scl_l.fall) begin
            drv_req = 1'b1;
            cnt_d   = '0;
            if (!ack_bit_q) begin
              state_d = RD_DATA;
              tx_d    = cur_byte[6:0];
              drv_oe  = ~cur_byte[7];
            end else begin
              state_d = IGNORE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      rx_q       <= '0;
      tx_q       <= '0;
      ptr_q      <= '0;
      ack_bit_q  <= 1'b1;
      oe_q       <= 1'b0;
      oe_ack_q   <= 1'b0;
      pend_oe_q  <= 1'b0;
      pend_ack_q <= 1'b0;
      hold_act_q <= 1'b0;
      hold_q     <= '0;
      wr_stb_q   <= 1'b0;
      wr_idx_q   <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      cnt_q     <= cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      ptr_q     <= ptr_d;
      ack_bit_q <= ack_bit_d;
      wr_stb_q  <= wr_en;
      if (wr_en) begin
        regs[ptr_q] <= wr_data;
        wr_idx_q    <= ptr_q;
      end
      // START/STOP happen with SCL high; the bus must already be free.
      if (start || stop) begin
        oe_q       <= 1'b0;
        oe_ack_q   <= 1'b0;
        hold_act_q <= 1'b0;
      end else if (drv_req) begin
        pend_oe_q  <= drv_oe;
        pend_ack_q <= drv_ack;
        hold_q     <= HOLD_W'(HOLD_CYCLES - 1);
        hold_act_q <= 1'b1;
      end else if (hold_act_q) begin
        if (hold_q == '0) begin
          oe_q       <= pend_oe_q;
          oe_ack_q   <= pend_ack_q;
          hold_act_q <= 1'b0;
        end else begin
          hold_q <= hold_q - 1'b1;
        end
      end
    end
  end

  // Gating with reset_n lets a reset release SDA without waiting for a clock.
  assign ck_sda = (oe_q && reset_n) ? 1'b0 : 1'bz;

  assign start_detected_w  = start;
  assign stop_detected_w   = stop;
  assign ack_in_progress_w = oe_q & oe_ack_q;
  assign busy_w            = (state_q == ADDR_ACK) || (state_q == PTR) || (state_q == PTR_ACK) ||
                             (state_q == WR_DATA)  || (state_q == WR_ACK) ||
                             (state_q == RD_DATA)  || (state_q == RD_ACK);
  assign reg_wr_stb        = wr_stb_q;
  assign reg_wr_idx        = wr_idx_q;
  assign dbg_state         = state_q;

  always_comb begin
    regs_flat = '0;
    for (int i = 0; i < NUM_REGS; i++) regs_flat[8*i +: 8] = regs[i];
  end

endmodule
